// File: rtl/psram_hdmi_disp_px.sv
// HDMI scan-out reader: drains the PSRAM line FIFO, unpacks RGB565/grey8
// words into RGB888 and delays de/hs/vs by a fixed three cycles.
module psram_hdmi_disp_px #(
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 6,
    parameter int BLK_AW  = 4,
    parameter int UCNT_W  = 8
) (
    input  logic               hdmiclk,
    input  logic               rst_hdclk,
    input  logic               start_hdmi,
    input  logic               stop_hdmi,
    input  logic               mode_fmt,
    input  logic               mode_hx2,
    input  logic               clr_flags,
    input  logic               fifo_empty,
    output logic [FIFO_AW-1:0] fifo_radr,
    output logic               fifo_ren,
    input  logic [DATA_W-1:0]  fifo_rdata,
    output logic               fifo_blk_tgl,
    input  logic               in_rgb_de,
    input  logic               in_rgb_hs,
    input  logic               in_rgb_vs,
    input  logic               in_frame_last_pix,
    output logic               run_timinggen,
    output logic               disp_run,
    output logic               out_rgb_de,
    output logic               out_rgb_hs,
    output logic               out_rgb_vs,
    output logic [7:0]         out_r,
    output logic [7:0]         out_g,
    output logic [7:0]         out_b,
    output logic               fifo_underrun,
    output logic [UCNT_W-1:0]  underrun_cnt,
    output logic               vsync_flag
);

    localparam int PPW16 = DATA_W / 16;
    localparam int PPW8  = DATA_W / 8;
    localparam int SPW   = $clog2(PPW8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t state;

    logic [2:0] start_s;
    logic [2:0] stop_s;
    logic [2:0] clr_s;
    logic [1:0] empty_sync;
    logic       start_rise;
    logic       stop_rise;
    logic       clr_rise;
    logic       empty_s;

    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp1;
    logic           rp;
    logic           fmt_q;
    logic           hx2_q;
    logic           active;
    logic           sp_last;
    logic           rp_last;

    logic        de1, hs1, vs1;
    logic        de2, hs2, vs2;
    logic [23:0] px2;
    logic [15:0] lane16;
    logic [7:0]  lane8;
    logic [23:0] px_exp;
    logic        underrun_hit;
    logic        vs_fall;

    assign start_rise = start_s[1] & ~start_s[2];
    assign stop_rise  = stop_s[1] & ~stop_s[2];
    assign clr_rise   = clr_s[1] & ~clr_s[2];
    assign empty_s    = empty_sync[1];

    // empty synchroniser resets to 1 so nothing is read before the FIFO is seen
    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk) begin
            start_s    <= '0;
            stop_s     <= '0;
            clr_s      <= '0;
            empty_sync <= 2'b11;
        end else begin
            start_s    <= {start_s[1:0], start_hdmi};
            stop_s     <= {stop_s[1:0], stop_hdmi};
            clr_s      <= {clr_s[1:0], clr_flags};
            empty_sync <= {empty_sync[0], fifo_empty};
        end
    end

    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk) begin
            state         <= S_IDLE;
            run_timinggen <= 1'b0;
            disp_run      <= 1'b0;
            fmt_q         <= 1'b0;
            hx2_q         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_rise)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (stop_rise) begin
                        state <= S_IDLE;
                    end else if (!empty_s) begin
                        state         <= S_RUN;
                        fmt_q         <= mode_fmt;
                        hx2_q         <= mode_hx2;
                        run_timinggen <= 1'b1;
                        disp_run      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop_rise)
                        state <= S_STOPPING;
                end
                S_STOPPING: begin
                    if (in_frame_last_pix) begin
                        state         <= S_IDLE;
                        run_timinggen <= 1'b0;
                        disp_run      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign active  = (state == S_RUN) || (state == S_STOPPING);
    assign sp_last = fmt_q ? (sp == SPW'(PPW8 - 1)) : (sp == SPW'(PPW16 - 1));
    assign rp_last = ~hx2_q | rp;
    assign fifo_ren = active & in_rgb_de & sp_last & rp_last;

    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk) begin
            fifo_radr    <= '0;
            sp           <= '0;
            rp           <= 1'b0;
            fifo_blk_tgl <= 1'b0;
        end else begin
            if (!active) begin
                fifo_radr <= '0;
                sp        <= '0;
                rp        <= 1'b0;
            end else if (in_rgb_de) begin
                if (rp_last) begin
                    rp <= 1'b0;
                    if (sp_last) begin
                        sp        <= '0;
                        fifo_radr <= fifo_radr + FIFO_AW'(1);
                    end else begin
                        sp <= sp + SPW'(1);
                    end
                end else begin
                    rp <= 1'b1;
                end
            end
            if (fifo_ren && (&fifo_radr[BLK_AW-1:0]))
                fifo_blk_tgl <= ~fifo_blk_tgl;
        end
    end

    // FIFO data arrives one cycle after the address, so lane select uses sp1
    always_comb begin
        lane16 = '0;
        lane8  = '0;
        for (int k = 0; k < PPW16; k++)
            if (sp1 == SPW'(k))
                lane16 = fifo_rdata[16*k +: 16];
        for (int k = 0; k < PPW8; k++)
            if (sp1 == SPW'(k))
                lane8 = fifo_rdata[8*k +: 8];
        if (fmt_q)
            px_exp = {3{lane8}};
        else
            px_exp = {lane16[15:11], {3{lane16[11]}},
                      lane16[10:5],  {2{lane16[5]}},
                      lane16[4:0],   {3{lane16[0]}}};
    end

    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk) begin
            de1        <= 1'b0;
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            sp1        <= '0;
            de2        <= 1'b0;
            hs2        <= 1'b0;
            vs2        <= 1'b0;
            px2        <= '0;
            out_rgb_de <= 1'b0;
            out_rgb_hs <= 1'b0;
            out_rgb_vs <= 1'b0;
            out_r      <= '0;
            out_g      <= '0;
            out_b      <= '0;
        end else begin
            de1        <= in_rgb_de;
            hs1        <= in_rgb_hs;
            vs1        <= in_rgb_vs;
            sp1        <= sp;
            de2        <= de1;
            hs2        <= hs1;
            vs2        <= vs1;
            px2        <= px_exp;
            out_rgb_de <= run_timinggen & de2;
            out_rgb_hs <= run_timinggen & hs2;
            out_rgb_vs <= run_timinggen & vs2;
            {out_r, out_g, out_b} <= (run_timinggen & de2) ? px2 : 24'd0;
        end
    end

    assign underrun_hit = active & in_rgb_de & empty_s;
    assign vs_fall      = vs2 & ~vs1;

    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk) begin
            fifo_underrun <= 1'b0;
            underrun_cnt  <= '0;
            vsync_flag    <= 1'b0;
        end else begin
            if (underrun_hit) begin
                fifo_underrun <= 1'b1;
                if (!(&underrun_cnt))
                    underrun_cnt <= underrun_cnt + UCNT_W'(1);
            end else if (clr_rise) begin
                fifo_underrun <= 1'b0;
                underrun_cnt  <= '0;
            end
            if (vs_fall)
                vsync_flag <= 1'b1;
            else if (clr_rise)
                vsync_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psram_hdmi_disp_px.sv
// Randomised bench for psram_hdmi_disp_px: behavioural pixel-stream model,
// FIFO memory model and a small frame generator driven by run_timinggen.
module tb_psram_hdmi_disp_px;

    logic        hdmiclk;
    logic        rst_hdclk;
    logic        start_hdmi, stop_hdmi, mode_fmt, mode_hx2, clr_flags;
    logic        fifo_empty;
    logic [5:0]  fifo_radr;
    logic        fifo_ren;
    logic [31:0] fifo_rdata;
    logic        fifo_blk_tgl;
    logic        in_rgb_de, in_rgb_hs, in_rgb_vs, in_frame_last_pix;
    logic        run_timinggen, disp_run;
    logic        out_rgb_de, out_rgb_hs, out_rgb_vs;
    logic [7:0]  out_r, out_g, out_b;
    logic        fifo_underrun;
    logic [7:0]  underrun_cnt;
    logic        vsync_flag;

    psram_hdmi_disp_px #(
        .DATA_W(32), .FIFO_AW(6), .BLK_AW(4), .UCNT_W(8)
    ) dut (
        .hdmiclk(hdmiclk), .rst_hdclk(rst_hdclk),
        .start_hdmi(start_hdmi), .stop_hdmi(stop_hdmi),
        .mode_fmt(mode_fmt), .mode_hx2(mode_hx2), .clr_flags(clr_flags),
        .fifo_empty(fifo_empty), .fifo_radr(fifo_radr), .fifo_ren(fifo_ren),
        .fifo_rdata(fifo_rdata), .fifo_blk_tgl(fifo_blk_tgl),
        .in_rgb_de(in_rgb_de), .in_rgb_hs(in_rgb_hs), .in_rgb_vs(in_rgb_vs),
        .in_frame_last_pix(in_frame_last_pix),
        .run_timinggen(run_timinggen), .disp_run(disp_run),
        .out_rgb_de(out_rgb_de), .out_rgb_hs(out_rgb_hs), .out_rgb_vs(out_rgb_vs),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .fifo_underrun(fifo_underrun), .underrun_cnt(underrun_cnt),
        .vsync_flag(vsync_flag)
    );

    initial hdmiclk = 1'b0;
    always #5 hdmiclk = ~hdmiclk;

    logic [31:0] mem [0:63];
    always @(posedge hdmiclk) fifo_rdata <= mem[fifo_radr];

    int total = 0;
    int bad   = 0;

    // model state
    int          widx, sub, rep;
    bit          mfmt, mhx2;
    logic [23:0] pxq [$];
    bit   [2:0]  dl_de, dl_hs, dl_vs;
    bit          mblk, uflag, vflag, vs_prev, eh0, eh1, chk_adr;
    int          ucnt;
    int          gh, gv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ppw();
        return mfmt ? 4 : 2;
    endfunction

    function automatic int rcnt();
        return mhx2 ? 2 : 1;
    endfunction

    function automatic logic [23:0] exp_px(input logic [31:0] w, input int k, input bit fmt);
        logic [15:0] h;
        logic [7:0]  y;
        int r5, g6, b5, r8, g8, b8;
        if (fmt) begin
            y = 8'(w >> (8 * k));
            return {y, y, y};
        end
        h  = 16'(w >> (16 * k));
        r5 = int'(h) / 2048;
        g6 = (int'(h) / 32) % 64;
        b5 = int'(h) % 32;
        r8 = r5 * 8 + ((r5 % 2) * 7);
        g8 = g6 * 4 + ((g6 % 2) * 3);
        b8 = b5 * 8 + ((b5 % 2) * 7);
        return {8'(r8), 8'(g8), 8'(b8)};
    endfunction

    task automatic mdl_reset();
        widx = 0; sub = 0; rep = 0;
        pxq.delete();
        dl_de = '0; dl_hs = '0; dl_vs = '0;
        mblk = 0; uflag = 0; vflag = 0; ucnt = 0;
        vs_prev = 0; eh0 = 1; eh1 = 1; chk_adr = 0;
        gh = 0; gv = 0;
    endtask

    task automatic cyc();
        bit d, hs_i, vs_i, es, exp_ren;
        logic [23:0] e;
        #1;
        exp_ren = in_rgb_de && (sub == ppw() - 1) && (rep == rcnt() - 1);
        chk("ren", fifo_ren, exp_ren);
        if (chk_adr)
            chk("radr", fifo_radr, widx % 64);
        d = in_rgb_de; hs_i = in_rgb_hs; vs_i = in_rgb_vs;
        @(posedge hdmiclk);
        es = eh1; eh1 = eh0; eh0 = fifo_empty;
        if (d) begin
            pxq.push_back(exp_px(mem[widx % 64], sub, mfmt));
            if (es) begin
                uflag = 1;
                if (ucnt < 255) ucnt++;
            end
            rep++;
            if (rep == rcnt()) begin
                rep = 0;
                sub++;
                if (sub == ppw()) begin
                    sub = 0;
                    if (widx % 16 == 15) mblk = ~mblk;
                    widx++;
                end
            end
        end
        if (vs_prev && !vs_i) vflag = 1;
        vs_prev = vs_i;
        dl_de = {dl_de[1:0], d};
        dl_hs = {dl_hs[1:0], hs_i};
        dl_vs = {dl_vs[1:0], vs_i};
        #1;
        chk("out_de", out_rgb_de, dl_de[2]);
        chk("out_hs", out_rgb_hs, dl_hs[2]);
        chk("out_vs", out_rgb_vs, dl_vs[2]);
        if (dl_de[2]) begin
            if (pxq.size() == 0) begin
                chk("pxq_underflow", 1, 0);
            end else begin
                e = pxq.pop_front();
                chk("rgb", {out_r, out_g, out_b}, e);
            end
        end else begin
            chk("rgb_blank", {out_r, out_g, out_b}, 24'd0);
        end
        chk("blk_tgl", fifo_blk_tgl, mblk);
        // frame generator: 16 clocks/line (8 active), 4 lines/frame
        if (run_timinggen) begin
            in_rgb_de         = (gh < 8);
            in_rgb_hs         = (gh == 10 || gh == 11);
            in_rgb_vs         = (gv == 0);
            in_frame_last_pix = (gv == 3 && gh == 15);
            gh++;
            if (gh == 16) begin
                gh = 0;
                gv = (gv + 1) % 4;
            end
        end else begin
            in_rgb_de = 0; in_rgb_hs = 0; in_rgb_vs = 0; in_frame_last_pix = 0;
            gh = 0; gv = 0;
        end
    endtask

    task automatic run_for(input int n, input bit rnd_empty);
        repeat (n) begin
            if ($urandom_range(0, 15) == 0)
                {mode_fmt, mode_hx2} = 2'($urandom);
            if (rnd_empty && $urandom_range(0, 39) == 0)
                fifo_empty = ~fifo_empty;
            cyc();
        end
    endtask

    task automatic wait_rt(input bit v, input int budget, input string tag);
        int n = 0;
        while (run_timinggen !== v && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, run_timinggen, v);
    endtask

    task automatic prep_run(input bit fmt, input bit hx2);
        mode_fmt = fmt; mode_hx2 = hx2;
        mfmt = fmt; mhx2 = hx2;
        widx = 0; sub = 0; rep = 0;
        start_hdmi = 0; stop_hdmi = 0;
        repeat (4) cyc();
        start_hdmi = 1;
    endtask

    task automatic start_run(input bit fmt, input bit hx2);
        prep_run(fmt, hx2);
        wait_rt(1, 20, "run_on");
        chk("disp_on", disp_run, 1);
        chk_adr = 1;
    endtask

    task automatic stop_run();
        chk_adr = 0;
        stop_hdmi = 1;
        wait_rt(0, 300, "run_off");
        chk("disp_off", disp_run, 0);
        stop_hdmi = 0;
        repeat (5) cyc();
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_uflag"}, fifo_underrun, uflag);
        chk({tag, "_ucnt"}, underrun_cnt, ucnt);
        chk({tag, "_vflag"}, vsync_flag, vflag);
    endtask

    task automatic clear_flags();
        clr_flags = 1;
        repeat (6) cyc();
        clr_flags = 0;
        uflag = 0; ucnt = 0; vflag = 0;
        repeat (4) cyc();
        chk_flags("clr");
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_radr"}, fifo_radr, 0);
        chk({tag, "_ren"}, fifo_ren, 0);
        chk({tag, "_blk"}, fifo_blk_tgl, 0);
        chk({tag, "_rt"}, run_timinggen, 0);
        chk({tag, "_disp"}, disp_run, 0);
        chk({tag, "_syncs"}, {out_rgb_de, out_rgb_hs, out_rgb_vs}, 0);
        chk({tag, "_rgb"}, {out_r, out_g, out_b}, 0);
        chk({tag, "_flags"}, {fifo_underrun, underrun_cnt, vsync_flag}, 0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    initial begin
        rst_hdclk = 1;
        start_hdmi = 0; stop_hdmi = 0; clr_flags = 0;
        mode_fmt = 0; mode_hx2 = 0; fifo_empty = 1;
        in_rgb_de = 0; in_rgb_hs = 0; in_rgb_vs = 0; in_frame_last_pix = 0;
        fill_mem();
        mdl_reset();
        #3;
        chk_zero_outs("reset");
        repeat (3) cyc();
        mdl_reset();
        rst_hdclk = 0;
        fifo_empty = 0;
        repeat (3) cyc();
        chk("idle_rt", run_timinggen, 0);

        // RGB565, single width
        mem[0] = 32'hF800_07E0;
        start_run(0, 0);
        run_for(140, 0);
        stop_run();

        // grey8, doubled
        mem[0] = 32'h4030_2010;
        start_run(1, 1);
        run_for(140, 0);
        stop_run();

        // held in WAIT while the FIFO is empty
        fifo_empty = 1;
        repeat (3) cyc();
        prep_run(0, 0);
        repeat (100) cyc();
        chk("wait_rt", run_timinggen, 0);
        chk("wait_disp", disp_run, 0);
        fifo_empty = 0;
        wait_rt(1, 3, "wait_exit");
        chk_adr = 1;
        run_for(400, 0);

        // stop mid-frame, start rise while stopping must be ignored
        start_hdmi = 0;
        begin
            int n = 0;
            while (!(gv == 1 && gh == 0) && n < 200) begin
                cyc();
                n++;
            end
            chk("find_line1", (gv == 1 && gh == 0), 1);
        end
        chk_adr = 0;
        stop_hdmi = 1;
        repeat (6) cyc();
        chk("stopping_disp", disp_run, 1);
        chk("stopping_rt", run_timinggen, 1);
        start_hdmi = 1;
        wait_rt(0, 300, "stop_exit");
        chk("stop_exit_disp", disp_run, 0);
        repeat (60) cyc();
        chk("start_ignored", run_timinggen, 0);
        stop_hdmi = 0;
        chk_flags("pre_ur");

        // long underrun saturates the counter
        start_run(1'($urandom), 1'($urandom));
        fifo_empty = 1;
        run_for(650, 0);
        fifo_empty = 0;
        stop_run();
        chk_flags("sat");
        clear_flags();

        // random runs with sporadic empty windows
        for (int it = 0; it < 4; it++) begin
            fill_mem();
            repeat (2) cyc();
            start_run(1'($urandom), 1'($urandom));
            run_for($urandom_range(100, 300), 1);
            fifo_empty = 0;
            stop_run();
            chk_flags("rnd");
            clear_flags();
        end

        // asynchronous reset in the middle of a frame
        start_run(1'($urandom), 1'($urandom));
        run_for(50, 0);
        #2;
        rst_hdclk = 1;
        start_hdmi = 0;
        in_rgb_de = 0; in_rgb_hs = 0; in_rgb_vs = 0; in_frame_last_pix = 0;
        mdl_reset();
        #1;
        chk_zero_outs("midrst");
        repeat (2) cyc();
        mdl_reset();
        rst_hdclk = 0;
        chk_adr = 1;
        repeat (20) cyc();
        chk("post_rst_rt", run_timinggen, 0);
        chk_flags("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
